// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - shared types and the sensor init table for the I2C config sequencer
package i2c_cfg_pkg;

  localparam int MAX_REGS = 8;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACC  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_READY     = 3'd4,
    ST_ERR       = 3'd5
  } state_t;

  typedef enum logic {
    SRC_INIT = 1'b0,
    SRC_HOST = 1'b1
  } src_t;

  typedef struct packed {
    logic [7:0] sub;
    logic [7:0] data;
  } cfg_entry_t;

  // Entry 0 sits in the least significant 16 bits.
  localparam logic [MAX_REGS*16-1:0] INIT_TABLE = {
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h2400, 16'h2208, 16'h2330, 16'h200F
  };

endpackage

// File: rtl/i2c_cfg_rom.sv
// rtl/i2c_cfg_rom.sv - combinational index to {sub, data} lookup on the init table
module i2c_cfg_rom
  import i2c_cfg_pkg::*;
(
  input  logic [2:0] i_idx,
  output cfg_entry_t o_entry
);

  assign o_entry = INIT_TABLE[{i_idx, 4'b0000} +: 16];

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - walks the sensor init table through the I2C master, then serves host writes
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'b1101000,
  parameter int         N_REGS      = 4,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_ready,
  output logic       i2c_start,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_sub,
  output logic [7:0] i2c_data,
  input  logic       host_req,
  input  logic [7:0] host_sub,
  input  logic [7:0] host_data,
  output logic       host_ack,
  input  logic       reinit,
  output logic       init_done,
  output logic       busy,
  output logic       error
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]       LAST_IDX = 3'(N_REGS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t           r_state;
  src_t             r_src;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic [6:0]       r_addr;
  logic [7:0]       r_sub;
  logic [7:0]       r_data;
  logic             r_host_ack;
  logic             r_init_done;
  logic             r_busy;
  logic             r_error;
  cfg_entry_t       w_rom;

  i2c_cfg_rom u_rom (
    .i_idx   (r_idx),
    .o_entry (w_rom)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_WAIT_IDLE;
      r_src       <= SRC_INIT;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_addr      <= ADDR;
      r_sub       <= '0;
      r_data      <= '0;
      r_host_ack  <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
      r_error     <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_host_ack <= 1'b0;
      r_addr     <= ADDR;
      case (r_state)
        ST_WAIT_IDLE: begin
          r_idx <= '0;
          r_src <= SRC_INIT;
          if (i2c_ready) r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (r_src == SRC_HOST) begin
            r_sub  <= host_sub;
            r_data <= host_data;
          end else begin
            r_sub  <= w_rom.sub;
            r_data <= w_rom.data;
          end
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_WAIT_ACC;
        end
        ST_WAIT_ACC: begin
          if (!i2c_ready) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_ERR;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (i2c_ready) begin
            if (r_src == SRC_HOST) begin
              r_host_ack <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_READY;
            end else if (r_idx == LAST_IDX) begin
              r_init_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_READY;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_READY: begin
          // The host still holds host_req during its ack cycle; don't reissue it.
          if (reinit) begin
            r_init_done <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_WAIT_IDLE;
          end else if (host_req && !r_host_ack) begin
            r_src   <= SRC_HOST;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ERR: begin
          if (reinit) begin
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT_IDLE;
          end
        end
        default: r_state <= ST_WAIT_IDLE;
      endcase
    end
  end

  assign i2c_start = r_start;
  assign i2c_addr  = r_addr;
  assign i2c_sub   = r_sub;
  assign i2c_data  = r_data;
  assign host_ack  = r_host_ack;
  assign init_done = r_init_done;
  assign busy      = r_busy;
  assign error     = r_error;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - scoreboard bench for the I2C config sequencer
module tb_i2c_cfg_sequencer;

  localparam logic [6:0] ADDR = 7'b1101000;

  typedef struct packed {
    logic [7:0] sub;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rst1 = 1'b1;
  logic       m_ready = 1'b1;
  logic       m1_ready = 1'b1;
  logic       host_req = 1'b0;
  logic [7:0] host_sub = 8'h00;
  logic [7:0] host_data = 8'h00;
  logic       reinit = 1'b0;
  logic       i2c_start, host_ack, init_done, busy, error;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_sub, i2c_data;
  logic       d1_start, d1_ack, d1_init_done, d1_busy, d1_error;
  logic [6:0] d1_addr;
  logic [7:0] d1_sub, d1_data;

  exp_t exp_q[$];
  int   exp_ack = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   n_starts = 0;
  int   n1_starts = 0;
  int   cyc_last_start = 0;
  int   cyc_ready_rise = 0;
  int   m_cnt = 0;
  int   m1_cnt = 0;
  logic [7:0] m_hang_sub = 8'hFF;
  logic prev_start = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_done = 1'b0;

  i2c_cfg_sequencer #(.ADDR(ADDR), .N_REGS(4), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .i2c_ready(m_ready), .i2c_start(i2c_start),
    .i2c_addr(i2c_addr), .i2c_sub(i2c_sub), .i2c_data(i2c_data),
    .host_req(host_req), .host_sub(host_sub), .host_data(host_data),
    .host_ack(host_ack), .reinit(reinit), .init_done(init_done),
    .busy(busy), .error(error)
  );

  i2c_cfg_sequencer #(.ADDR(ADDR), .N_REGS(1), .ACK_TIMEOUT(16)) dut1 (
    .clk(clk), .reset(rst1), .i2c_ready(m1_ready), .i2c_start(d1_start),
    .i2c_addr(d1_addr), .i2c_sub(d1_sub), .i2c_data(d1_data),
    .host_req(1'b0), .host_sub(8'h00), .host_data(8'h00),
    .host_ack(d1_ack), .reinit(1'b0), .init_done(d1_init_done),
    .busy(d1_busy), .error(d1_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout_fail(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] d);
    exp_q.push_back(exp_t'({s, d}));
  endtask

  task automatic push_init();
    push(8'h20, 8'h0F);
    push(8'h23, 8'h30);
    push(8'h22, 8'h08);
    push(8'h24, 8'h00);
  endtask

  function automatic logic sel_sig(input int which);
    case (which)
      0:       return init_done;
      1:       return host_ack;
      2:       return error;
      default: return i2c_start;
    endcase
  endfunction

  task automatic wait_for(input int which, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (sel_sig(which)) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_starts(input int target, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (n_starts >= target) return;
    end
    timeout_fail(name);
  endtask

  task automatic pulse_reinit();
    @(negedge clk);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, i2c_start, 0);
    chk({tag, "_addr"}, i2c_addr, ADDR);
    chk({tag, "_sub"}, i2c_sub, 0);
    chk({tag, "_data"}, i2c_data, 0);
    chk({tag, "_ack"}, host_ack, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_error"}, error, 0);
  endtask

  // Master model: accepts a start at once, then stays busy for 20 cycles.
  always @(negedge clk) begin
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_ready = 1'b1;
        cyc_ready_rise = cyc;
      end
    end else if (i2c_start && i2c_sub != m_hang_sub) begin
      m_ready = 1'b0;
      m_cnt = 20;
    end
  end

  always @(negedge clk) begin
    if (m1_cnt > 0) begin
      m1_cnt--;
      if (m1_cnt == 0) m1_ready = 1'b1;
    end else if (d1_start) begin
      m1_ready = 1'b0;
      m1_cnt = 20;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (i2c_start) begin
      n_starts++;
      cyc_last_start = cyc;
      chk("start_width", prev_start, 0);
      chk("start_addr", i2c_addr, ADDR);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_start: sub=%0h data=%0h, none expected", i2c_sub, i2c_data);
      end else begin
        e = exp_q.pop_front();
        chk("start_sub", i2c_sub, e.sub);
        chk("start_data", i2c_data, e.data);
        if (e.sub == 8'h23 || e.sub == 8'h22 || e.sub == 8'h24)
          chk("b2b_latency", cyc - cyc_ready_rise, 2);
      end
    end
    if (host_ack) begin
      chk("ack_width", prev_ack, 0);
      if (exp_ack == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: host_ack=1, none expected");
      end else begin
        exp_ack--;
      end
    end
    if (init_done && !prev_done) begin
      chk("done_latency", cyc - cyc_ready_rise, 1);
      chk("done_busy", busy, 0);
    end
    if (d1_start) begin
      n1_starts++;
      chk("n1_sub", d1_sub, 8'h20);
      chk("n1_data", d1_data, 8'h0F);
    end
    prev_start = i2c_start;
    prev_ack = host_ack;
    prev_done = init_done;
  end

  initial begin
    int h;
    int base;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    push_init();
    reset = 1'b0;
    rst1 = 1'b0;

    // Host request during init entry 2 waits for init_done.
    wait_starts(3, 200, "init_entry2");
    host_req = 1'b1;
    host_sub = 8'h21;
    host_data = 8'hAA;
    push(8'h21, 8'hAA);
    exp_ack++;
    wait_for(0, 200, "init_done_1");
    wait_for(1, 100, "host_ack_1");
    host_req = 1'b0;
    host_sub = 8'hFF;
    host_data = 8'h00;
    repeat (5) @(negedge clk);
    chk("hold_sub", i2c_sub, 8'h21);
    chk("hold_data", i2c_data, 8'hAA);
    chk("idle_busy", busy, 0);
    chk("idle_done", init_done, 1);

    // Host write from READY: start two cycles after request.
    host_req = 1'b1;
    host_sub = 8'h2E;
    host_data = 8'h5A;
    h = cyc;
    push(8'h2E, 8'h5A);
    exp_ack++;
    wait_for(3, 20, "host_start_2");
    chk("host_start_lat", cyc - h, 2);
    wait_for(1, 100, "host_ack_2");
    host_req = 1'b0;

    // Entry 1 never accepted: timeout into ERR.
    m_hang_sub = 8'h23;
    push(8'h20, 8'h0F);
    push(8'h23, 8'h30);
    pulse_reinit();
    chk("reinit_clr_done", init_done, 0);
    chk("reinit_busy", busy, 1);
    wait_for(2, 200, "error_rise");
    chk("err_latency", cyc - cyc_last_start, 16);
    chk("err_busy", busy, 0);
    host_req = 1'b1;
    host_sub = 8'h77;
    host_data = 8'h77;
    repeat (30) @(negedge clk);
    host_req = 1'b0;
    chk("err_sticky", error, 1);
    chk("err_no_starts", exp_q.size(), 0);
    m_hang_sub = 8'hFF;
    push_init();
    pulse_reinit();
    chk("err_cleared", error, 0);
    chk("err_reinit_busy", busy, 1);
    wait_for(0, 300, "init_done_2");

    // reinit beats host_req in the same READY cycle.
    @(negedge clk);
    reinit = 1'b1;
    host_req = 1'b1;
    host_sub = 8'h55;
    host_data = 8'h66;
    push_init();
    push(8'h55, 8'h66);
    exp_ack++;
    @(negedge clk);
    reinit = 1'b0;
    wait_for(0, 300, "init_done_3");
    wait_for(1, 100, "host_ack_3");
    host_req = 1'b0;

    // Reset while entry 3 is in WAIT_DONE, then full replay.
    base = n_starts;
    push_init();
    pulse_reinit();
    wait_starts(base + 4, 300, "entry3_start");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    push_init();
    wait_for(0, 400, "init_done_4");

    repeat (5) @(negedge clk);
    chk("q_empty", exp_q.size(), 0);
    chk("ack_balance", exp_ack, 0);
    chk("n1_starts", n1_starts, 1);
    chk("n1_done", d1_init_done, 1);
    chk("n1_error", d1_error, 0);
    chk("n1_busy", d1_busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_sequencer.md
# i2c_cfg_sequencer

Sequencing controller in front of `I2C_master`. After reset it configures the on-board sensor at 7-bit address `ADDR`: it walks a fixed init table of (sub-register, data) pairs and issues one I2C register write per entry through the master's start/ready handshake. Once init completes, it shares the same master with a single host requester that issues ad-hoc register writes. It runs in the I2C clock domain (`I2C_clk_div` output) and drives the master's `addr`, `sub`, `data` and `start` inputs directly.

## Interface
- `ADDR`, 7'b1101000: slave address placed on `i2c_addr` for every transaction.
- `N_REGS`, 4: number of init table entries used, 1..8.
- `ACK_TIMEOUT`, 16: cycles allowed for `i2c_ready` to fall after `i2c_start`.
- `clk`  in  1: I2C-domain clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `i2c_ready`  in  1: master idle/done; high = idle.
- `i2c_start`  out  1: one-cycle transaction request to the master.
- `i2c_addr`  out  7: always `ADDR`.
- `i2c_sub`  out  8: register address of the current write.
- `i2c_data`  out  8: data byte of the current write.
- `host_req`  in  1: level request; held until `host_ack`.
- `host_sub`  in  8: host register address, sampled at issue.
- `host_data`  in  8: host data byte, sampled at issue.
- `host_ack`  out  1: one-cycle pulse when the host write completes.
- `reinit`  in  1: one-cycle pulse; replays the init table.
- `init_done`  out  1: high after the last init entry completes.
- `busy`  out  1: high in every state except READY and ERR.
- `error`  out  1: sticky timeout flag.

## Operation
- States: WAIT_IDLE, ISSUE, WAIT_ACC, WAIT_DONE, READY, ERR. A `src` bit (INIT/HOST) and a 3-bit `idx` qualify ISSUE, WAIT_ACC and WAIT_DONE.
- WAIT_IDLE: `idx`=0, `src`=INIT. Go to ISSUE when `i2c_ready`=1.
- ISSUE: load `i2c_sub`/`i2c_data` from `INIT_TABLE[idx]`, or from `host_sub`/`host_data` when `src`=HOST. Pulse `i2c_start`. Go to WAIT_ACC.
- WAIT_ACC: on `i2c_ready`=0, go to WAIT_DONE. If the timeout counter reaches `ACK_TIMEOUT` first, go to ERR.
- WAIT_DONE: when `i2c_ready`=1:
  - INIT with `idx`<`N_REGS`-1: `idx`++, go to ISSUE.
  - INIT on the last entry: set `init_done`, go to READY.
  - HOST: pulse `host_ack`, go to READY.
- WAIT_DONE has no timeout; the master guarantees completion.
- READY:
  - `reinit`=1: clear `init_done`, go to WAIT_IDLE.
  - Else `host_req`=1: `src`=HOST, go to ISSUE.
  - `reinit` has priority over `host_req` in the same cycle.
- ERR: `error`=1, `busy`=0, `init_done` keeps its value. `reinit` clears `error` and goes to WAIT_IDLE. `host_req` is ignored.
- `host_req` asserted during init or during a host transaction stays pending. It is served from READY, never preempting an init entry.
- `reinit` outside READY/ERR is ignored.
- `i2c_sub`/`i2c_data` hold their value from ISSUE until the next ISSUE. Host inputs may change after `i2c_start`.

## Timing
- Reset values: `i2c_start`=0, `i2c_addr`=`ADDR`, `i2c_sub`=0, `i2c_data`=0, `host_ack`=0, `init_done`=0, `busy`=1, `error`=0, state WAIT_IDLE, `idx`=0.
- Reset asserted mid-transaction returns to WAIT_IDLE immediately. Init restarts from entry 0 once `i2c_ready`=1.
- All outputs are registered.
- `i2c_start` is high for exactly one cycle, the cycle after ISSUE is entered. Sub/data are valid in that same cycle.
- Timeout counter: clears on entry to WAIT_ACC and counts cycles with `i2c_ready`=1 after the start pulse. ERR is entered on the edge where count = `ACK_TIMEOUT`.
- From READY with `host_req`=1: `i2c_start` is high 2 cycles later.
- `host_ack` is high the cycle after `i2c_ready` is sampled high in WAIT_DONE.
- Back-to-back init entries: next `i2c_start` is 2 cycles after `i2c_ready` rises.

## Structure
- Package `i2c_cfg_pkg`:
  - state encoding constants;
  - `INIT_TABLE` of 8 × {sub, data}: {8'h20,8'h0F}, {8'h23,8'h30}, {8'h22,8'h08}, {8'h24,8'h00}, remaining entries 0;
  - `MAX_REGS`=8.
- Sub-module `i2c_cfg_rom`: combinational `idx` → {sub, data} lookup on `INIT_TABLE`.
- FSM, timeout counter and host latch live in the top module.

## Test plan
- Reset release with master model (accepts in 1 cycle, busy 20 cycles) → four starts with sub/data 20/0F, 23/30, 22/08, 24/00 in order. `init_done` rises one cycle after the 4th `i2c_ready` rise; `busy` falls with it.
- `host_req` with sub=8'h21, data=8'hAA asserted during init entry 2 → served only after `init_done`. Start carries 21/AA and `host_ack` pulses once. Outputs hold after `host_req` drops.
- Model never drops `i2c_ready` on entry 1 → `error`=1 exactly `ACK_TIMEOUT` cycles after the start pulse, `busy`=0, no further starts. `reinit` → `error`=0, init replays from entry 0.
- `reinit` and `host_req` in the same READY cycle → init replays first (20/0F issued first). The host write follows after `init_done`.
- `reset` asserted while in WAIT_DONE of entry 3 → all outputs at reset values. After release, the next start carries 20/0F.
- `N_REGS`=1 → single start with 20/0F, then `init_done`=1.
